// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - widths, load size codes and FSM states shared by the load unit
package mem_load_unit_pkg;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } ld_state_e;

    // Natural alignment: the byte offset must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic mis;
        case (size)
            LD_H:    mis = off[0];
            LD_W:    mis = |off[1:0];
            LD_D:    mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - shifts the addressed bytes of a doubleword down and sign/zero extends them
module load_align_ext
    import mem_load_unit_pkg::*;
(
    input  logic [XLEN-1:0] resp_data,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw  = resp_data >> {off, 3'b000};
        data = raw;
        case (size)
            LD_B:    data = {{(XLEN-8){~is_unsigned & raw[7]}},   raw[7:0]};
            LD_H:    data = {{(XLEN-16){~is_unsigned & raw[15]}}, raw[15:0]};
            LD_W:    data = {{(XLEN-32){~is_unsigned & raw[31]}}, raw[31:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - single-outstanding data-memory load unit between EX and wb_stage
module mem_load_unit
    import mem_load_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [XLEN-1:0]    ld_addr,
    input  logic [1:0]         ld_size,
    input  logic               ld_unsigned,
    input  logic [RADDR_W-1:0] ld_rd,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    output logic [XLEN-1:0]    dmem_req_addr,
    input  logic               dmem_resp_valid,
    input  logic [XLEN-1:0]    dmem_resp_data,
    output logic               wb_valid,
    output logic               wb_wen,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               ld_misalign
);

    ld_state_e          state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic               misalign_q, misalign_d;
    logic [XLEN-1:0]    ext_data;

    load_align_ext u_align_ext (
        .resp_data   (dmem_resp_data),
        .off         (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        rd_d           = rd_q;
        wb_data_d      = wb_data_q;
        misalign_d     = 1'b0;
        ld_ready       = 1'b0;
        dmem_req_valid = 1'b0;
        wb_valid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid && !flush) begin
                    addr_d     = ld_addr;
                    size_d     = ld_size;
                    unsigned_d = ld_unsigned;
                    rd_d       = ld_rd;
                    if (is_misaligned(ld_addr[2:0], ld_size)) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A flush here must never let the request reach memory.
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_resp_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        wb_data_d = ext_data;
                        state_d   = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The read is already in flight; swallow its response before taking new work.
                if (dmem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                wb_valid = !flush;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req_addr = {addr_q[XLEN-1:3], 3'b000};
    assign wb_wen        = wb_valid && (rd_q != '0);
    assign wb_rd         = rd_q;
    assign wb_data       = wb_data_q;
    assign ld_misalign   = misalign_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - randomized self-checking bench for mem_load_unit
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [4:0]  ld_rd;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ld_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    int          r_acc_ready, r_req_cnt, r_hs_cnt, r_mis_cnt, r_wb_cnt, r_lat, r_unstable;
    logic [63:0] r_req_addr, r_wb_data;
    logic        r_wb_wen;
    logic [4:0]  r_wb_rd;

    mem_load_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_size         (ld_size),
        .ld_unsigned     (ld_unsigned),
        .ld_rd           (ld_rd),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_data  (dmem_resp_data),
        .wb_valid        (wb_valid),
        .wb_wen          (wb_wen),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .ld_misalign     (ld_misalign)
    );

    always #5 clk = ~clk;

    // Reference: pick the addressed bytes out of memory little-endian, then fill the upper bytes.
    function automatic logic [63:0] ref_load(input logic [63:0] dw, input logic [2:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b [8];
        logic [63:0] r;
        int          n;
        logic        neg;
        for (int i = 0; i < 8; i++) b[i] = dw[i*8 +: 8];
        n = 1 << sz;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = b[int'(off) + i];
        neg = b[int'(off) + n - 1][7] && (!uns || n == 8);
        if (neg) for (int i = n; i < 8; i++) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    // Presents one load, plays memory with the given stalls, and records what the DUT did.
    task automatic run_load(input logic [63:0] a, input logic [1:0] sz, input logic u,
                            input logic [4:0] rd, input logic [63:0] resp,
                            input int stall, input int dly);
        int phase, s, d;
        phase = 0; s = stall; d = dly;
        r_req_cnt = 0; r_hs_cnt = 0; r_mis_cnt = 0; r_wb_cnt = 0; r_lat = -1; r_unstable = 0;
        r_req_addr = '0; r_wb_data = '0; r_wb_wen = 1'b0; r_wb_rd = '0;
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_unsigned = u; ld_rd = rd;
        #1;
        r_acc_ready = int'(ld_ready);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_addr  = {$urandom, $urandom};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            dmem_req_ready  = (phase == 0 && s == 0);
            dmem_resp_valid = (phase == 1 && d == 0);
            dmem_resp_data  = dmem_resp_valid ? resp : {$urandom, $urandom};
            #1;
            if (dmem_req_valid) begin
                if (r_req_cnt == 0) r_req_addr = dmem_req_addr;
                else if (dmem_req_addr !== r_req_addr) r_unstable = 1;
                r_req_cnt++;
                if (dmem_req_ready) r_hs_cnt++;
            end
            if (ld_misalign) r_mis_cnt++;
            if (wb_valid) begin
                if (r_wb_cnt == 0) begin
                    r_lat = cyc; r_wb_data = wb_data; r_wb_wen = wb_wen; r_wb_rd = wb_rd;
                end
                r_wb_cnt++;
            end
            if (phase == 0 && dmem_req_valid) begin
                if (s > 0) s--; else phase = 1;
            end else if (phase == 1) begin
                if (d > 0) d--; else phase = 2;
            end
            @(posedge clk); #1;
        end
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        n_tests++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", dmem_req_valid); end
        n_tests++; if (dmem_req_addr !== 64'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", dmem_req_addr); end
        n_tests++; if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wb_pulses: got %b%b expected 00", wb_valid, wb_wen); end
        n_tests++; if (wb_rd !== 5'd0 || wb_data !== 64'h0) begin n_fail++; $display("FAIL reset_wb_fields: got rd %0d data %h expected 0 0", wb_rd, wb_data); end
        n_tests++; if (ld_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", ld_misalign); end
    endtask

    task automatic test_spec_vectors();
        run_load(64'h8000_0004, 2'd2, 1'b0, 5'd9, 64'h8000_0001_DEAD_BEEF, 0, 0);
        n_tests++; if (r_req_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL lw_req_addr: got %h expected 0000000080000000", r_req_addr); end
        n_tests++; if (r_wb_data !== 64'hFFFF_FFFF_8000_0001) begin n_fail++; $display("FAIL lw_data: got %h expected ffffffff80000001", r_wb_data); end
        n_tests++; if (r_wb_wen !== 1'b1 || r_wb_rd !== 5'd9) begin n_fail++; $display("FAIL lw_wen_rd: got %b %0d expected 1 9", r_wb_wen, r_wb_rd); end
        n_tests++; if (r_lat != 3) begin n_fail++; $display("FAIL lw_latency: got %0d expected 3", r_lat); end

        run_load(64'h1000_0007, 2'd0, 1'b1, 5'd3, 64'hAB00_0000_0000_0000, 0, 1);
        n_tests++; if (r_wb_data !== 64'h0000_0000_0000_00AB) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000000000000ab", r_wb_data); end
        run_load(64'h1000_0007, 2'd0, 1'b0, 5'd3, 64'hAB00_0000_0000_0000, 0, 1);
        n_tests++; if (r_wb_data !== 64'hFFFF_FFFF_FFFF_FFAB) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffffffffffab", r_wb_data); end

        run_load(64'h1000_0003, 2'd1, 1'b0, 5'd4, 64'h1234, 0, 0);
        n_tests++; if (r_mis_cnt != 1) begin n_fail++; $display("FAIL lh_mis_pulse: got %0d cycles expected 1", r_mis_cnt); end
        n_tests++; if (r_req_cnt != 0 || r_wb_cnt != 0) begin n_fail++; $display("FAIL lh_mis_no_req: got req %0d wb %0d expected 0 0", r_req_cnt, r_wb_cnt); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL lh_mis_ready: got %b expected 1", ld_ready); end

        run_load(64'h2000_0010, 2'd3, 1'b0, 5'd5, 64'h0123_4567_89AB_CDEF, 4, 0);
        n_tests++; if (r_req_cnt != 5 || r_unstable != 0) begin n_fail++; $display("FAIL stall_req: got %0d cycles unstable %0d expected 5 0", r_req_cnt, r_unstable); end
        n_tests++; if (r_hs_cnt != 1 || r_wb_cnt != 1) begin n_fail++; $display("FAIL stall_counts: got hs %0d wb %0d expected 1 1", r_hs_cnt, r_wb_cnt); end
        n_tests++; if (r_wb_data !== 64'h0123_4567_89AB_CDEF || r_lat != 7) begin n_fail++; $display("FAIL stall_result: got %h lat %0d expected 0123456789abcdef 7", r_wb_data, r_lat); end
    endtask

    task automatic test_random();
        logic [63:0] a, resp, exp;
        logic [1:0]  sz;
        logic        u, exp_mis;
        logic [4:0]  rd;
        int          n, st, dl;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = a[2:0] & ~3'(n - 1);
            u  = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            resp = {$urandom, $urandom};
            st = $urandom_range(0, 3);
            dl = $urandom_range(0, 3);
            exp_mis = (int'(a[2:0]) % n) != 0;
            run_load(a, sz, u, rd, resp, st, dl);
            n_tests++; if (r_acc_ready != 1) begin n_fail++; $display("FAIL rand_accept[%0d]: got ld_ready %0d expected 1", i, r_acc_ready); end
            if (exp_mis) begin
                n_tests++; if (r_mis_cnt != 1 || r_req_cnt != 0 || r_wb_cnt != 0) begin n_fail++; $display("FAIL rand_mis[%0d]: got mis %0d req %0d wb %0d expected 1 0 0", i, r_mis_cnt, r_req_cnt, r_wb_cnt); end
            end else begin
                exp = ref_load(resp, a[2:0], sz, u);
                n_tests++; if (r_wb_cnt != 1 || r_hs_cnt != 1 || r_mis_cnt != 0) begin n_fail++; $display("FAIL rand_counts[%0d]: got wb %0d hs %0d mis %0d expected 1 1 0", i, r_wb_cnt, r_hs_cnt, r_mis_cnt); end
                n_tests++; if (r_wb_data !== exp) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, r_wb_data, exp); end
                n_tests++; if (r_req_addr !== (a & ~64'h7) || r_unstable != 0) begin n_fail++; $display("FAIL rand_req_addr[%0d]: got %h expected %h", i, r_req_addr, a & ~64'h7); end
                n_tests++; if (r_wb_wen !== (rd != 0) || r_wb_rd !== rd) begin n_fail++; $display("FAIL rand_wen_rd[%0d]: got %b %0d expected %b %0d", i, r_wb_wen, r_wb_rd, rd != 0, rd); end
                n_tests++; if (r_lat != 3 + st + dl) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, r_lat, 3 + st + dl); end
            end
        end
    endtask

    task automatic test_flush();
        int wb_seen;
        wb_seen = 0;
        // flush while the request is pending: nothing goes to memory
        ld_valid = 1'b1; ld_addr = 64'h3000_0008; ld_size = 2'd3; ld_unsigned = 1'b0; ld_rd = 5'd6;
        @(posedge clk); #1;
        ld_valid = 1'b0; flush = 1'b1; dmem_req_ready = 1'b1;
        #1;
        n_tests++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_valid: got %b expected 0", dmem_req_valid); end
        @(posedge clk); #1;
        flush = 1'b0; dmem_req_ready = 1'b0;
        #1;
        n_tests++; if (ld_ready !== 1'b1 || dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_idle: got ready %b req %b expected 1 0", ld_ready, dmem_req_valid); end

        // flush while waiting, response arrives two cycles later and must be dropped
        @(posedge clk); #1;
        ld_valid = 1'b1; dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0; flush = 1'b1;
        #1; if (wb_valid) wb_seen++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1; if (wb_valid) wb_seen++;
        n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_a: got %b expected 0", ld_ready); end
        @(posedge clk); #1;
        dmem_resp_valid = 1'b1; dmem_resp_data = 64'hFEED_FACE_CAFE_F00D;
        #1; if (wb_valid) wb_seen++;
        n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_b: got %b expected 0", ld_ready); end
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        #1;
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_after: got %b expected 1", ld_ready); end
        for (int k = 0; k < 3; k++) begin
            if (wb_valid) wb_seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (wb_seen != 0) begin n_fail++; $display("FAIL drain_no_wb: got %0d pulses expected 0", wb_seen); end

        run_load(64'h3000_0012, 2'd1, 1'b1, 5'd8, 64'h0000_0000_BEEF_0000, 1, 2);
        n_tests++; if (r_wb_cnt != 1 || r_wb_data !== 64'h0000_0000_0000_BEEF) begin n_fail++; $display("FAIL flush_recover: got wb %0d data %h expected 1 000000000000beef", r_wb_cnt, r_wb_data); end
    endtask

    task automatic test_rd0_and_reset();
        run_load(64'h4000_0018, 2'd3, 1'b1, 5'd0, 64'h8877_6655_4433_2211, 0, 0);
        n_tests++; if (r_wb_cnt != 1 || r_hs_cnt != 1) begin n_fail++; $display("FAIL rd0_counts: got wb %0d hs %0d expected 1 1", r_wb_cnt, r_hs_cnt); end
        n_tests++; if (r_wb_wen !== 1'b0 || r_wb_data !== 64'h8877_6655_4433_2211) begin n_fail++; $display("FAIL rd0_result: got wen %b data %h expected 0 8877665544332211", r_wb_wen, r_wb_data); end

        ld_valid = 1'b1; ld_addr = 64'h4000_0021; ld_size = 2'd0; ld_unsigned = 1'b0; ld_rd = 5'd17;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (ld_ready !== 1'b1 || dmem_req_valid !== 1'b0 || ld_misalign !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got ready %b req %b mis %b expected 1 0 0", ld_ready, dmem_req_valid, ld_misalign); end
        n_tests++; if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL midreset_wb: got v %b wen %b rd %0d expected 0 0 0", wb_valid, wb_wen, wb_rd); end
        n_tests++; if (wb_data !== 64'h0 || dmem_req_addr !== 64'h0) begin n_fail++; $display("FAIL midreset_data: got data %h addr %h expected 0 0", wb_data, dmem_req_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (ld_ready !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_idle: got ready %b wb %b expected 1 0", ld_ready, wb_valid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0;
        ld_rd = '0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_spec_vectors();
        test_random();
        test_flush();
        test_rd0_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
